// File: rtl/cs_video_pkg.sv
// Shared types, palette constants and channel helpers for the Computer Space video mixer.
package cs_video_pkg;

    localparam int CH_W  = 4;
    localparam int SUM_W = 6;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb4_t;

    typedef struct packed {
        logic [SUM_W-1:0] r;
        logic [SUM_W-1:0] g;
        logic [SUM_W-1:0] b;
    } rgb6_t;

    localparam rgb4_t PAL_SCORE       = {4'd7, 4'd7, 4'd7};
    localparam rgb4_t PAL_SAUCER_MONO = {4'd7, 4'd7, 4'd7};
    localparam rgb4_t PAL_SAUCER_COL  = {4'd0, 4'd15, 4'd15};
    localparam rgb4_t PAL_SHIP_MONO   = {4'd15, 4'd15, 4'd15};
    localparam rgb4_t PAL_SHIP_COL    = {4'd15, 4'd15, 4'd0};

    function automatic rgb6_t layer_term(rgb4_t pal, logic en);
        rgb6_t t;
        t.r = en ? {2'b00, pal.r} : '0;
        t.g = en ? {2'b00, pal.g} : '0;
        t.b = en ? {2'b00, pal.b} : '0;
        return t;
    endfunction

    function automatic logic [CH_W-1:0] sat_ch(logic [SUM_W-1:0] s);
        return (s > 6'd15) ? 4'hF : s[CH_W-1:0];
    endfunction

    function automatic rgb4_t saturate(rgb6_t s);
        rgb4_t o;
        o.r = sat_ch(s.r);
        o.g = sat_ch(s.g);
        o.b = sat_ch(s.b);
        return o;
    endfunction

endpackage

// File: rtl/cs_video_mixer_inv_tracker.sv
// Frame-synchronous screen-inversion tracker: sticky request, vsync edge, hold counter.
module cs_inv_tracker #(
    parameter int INV_HOLD_FRAMES = 1
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic ce_pix,
    input  logic vs_in,
    input  logic inv_req,
    output logic inv
);

    localparam logic [3:0] HOLD = INV_HOLD_FRAMES[3:0];

    logic       vs_prev_q, vs_prev_d;
    logic       req_q, req_d;
    logic [3:0] cnt_q, cnt_d;
    logic       edge_vs;

    always_comb begin
        vs_prev_d = vs_prev_q;
        req_d     = req_q;
        cnt_d     = cnt_q;
        edge_vs   = 1'b0;
        if (ce_pix) begin
            edge_vs   = vs_in & ~vs_prev_q;
            vs_prev_d = vs_in;
            if (edge_vs) begin
                // counter consumes the old request; a request on this cycle
                // belongs to the frame that is just starting
                if (req_q)
                    cnt_d = HOLD;
                else if (cnt_q != 4'd0)
                    cnt_d = cnt_q - 4'd1;
                req_d = inv_req;
            end else begin
                req_d = req_q | inv_req;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev_q <= 1'b0;
            req_q     <= 1'b0;
            cnt_q     <= 4'd0;
        end else begin
            vs_prev_q <= vs_prev_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
        end
    end

    assign inv = (cnt_q != 4'd0);

endmodule

// File: rtl/cs_video_mixer.sv
// Two-stage layer-to-RGB mixer with saturating palette and inversion flash.
// Optional colour palette enabled by defining CS_VIDEO_COLOR_EN.
module cs_video_mixer
    import cs_video_pkg::*;
#(
    parameter int INV_HOLD_FRAMES = 1
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            ce_pix,
    input  logic            color,
    input  logic [3:0]      video_in,
    input  logic            hs_in,
    input  logic            vs_in,
    input  logic            blank_in,
    output logic [CH_W-1:0] r_out,
    output logic [CH_W-1:0] g_out,
    output logic [CH_W-1:0] b_out,
    output logic            hs_out,
    output logic            vs_out,
    output logic            blank_out,
    output logic            inv_active
);

    logic [2:0] lay_q, lay_d;
    logic       hs1_q, hs1_d;
    logic       vs1_q, vs1_d;
    logic       blank1_q, blank1_d;

    rgb4_t      rgb_q, rgb_d;
    logic       hs2_q, hs2_d;
    logic       vs2_q, vs2_d;
    logic       blank2_q, blank2_d;

    logic       inv;
    logic       use_col;
    rgb4_t      pal_saucer, pal_ship, sat, mixed;
    rgb6_t      t_score, t_saucer, t_ship, sum;

`ifdef CS_VIDEO_COLOR_EN
    assign use_col = color;
`else
    logic unused_color;
    assign unused_color = color;
    assign use_col      = 1'b0;
`endif

    cs_inv_tracker #(
        .INV_HOLD_FRAMES(INV_HOLD_FRAMES)
    ) u_inv (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .ce_pix (ce_pix),
        .vs_in  (vs_in),
        .inv_req(video_in[3]),
        .inv    (inv)
    );

    always_comb begin
        pal_saucer = use_col ? PAL_SAUCER_COL : PAL_SAUCER_MONO;
        pal_ship   = use_col ? PAL_SHIP_COL : PAL_SHIP_MONO;
        t_score    = layer_term(PAL_SCORE, lay_q[0]);
        t_saucer   = layer_term(pal_saucer, lay_q[1]);
        t_ship     = layer_term(pal_ship, lay_q[2]);
        sum.r      = t_score.r + t_saucer.r + t_ship.r;
        sum.g      = t_score.g + t_saucer.g + t_ship.g;
        sum.b      = t_score.b + t_saucer.b + t_ship.b;
        sat        = saturate(sum);
        mixed      = sat ^ {3*CH_W{inv}};
        if (blank1_q)
            mixed = '0;
    end

    always_comb begin
        lay_d    = lay_q;
        hs1_d    = hs1_q;
        vs1_d    = vs1_q;
        blank1_d = blank1_q;
        rgb_d    = rgb_q;
        hs2_d    = hs2_q;
        vs2_d    = vs2_q;
        blank2_d = blank2_q;
        if (ce_pix) begin
            lay_d    = video_in[2:0];
            hs1_d    = hs_in;
            vs1_d    = vs_in;
            blank1_d = blank_in;
            rgb_d    = mixed;
            hs2_d    = hs1_q;
            vs2_d    = vs1_q;
            blank2_d = blank1_q;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            lay_q    <= '0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            blank1_q <= 1'b1;
            rgb_q    <= '0;
            hs2_q    <= 1'b0;
            vs2_q    <= 1'b0;
            blank2_q <= 1'b1;
        end else begin
            lay_q    <= lay_d;
            hs1_q    <= hs1_d;
            vs1_q    <= vs1_d;
            blank1_q <= blank1_d;
            rgb_q    <= rgb_d;
            hs2_q    <= hs2_d;
            vs2_q    <= vs2_d;
            blank2_q <= blank2_d;
        end
    end

    assign r_out      = rgb_q.r;
    assign g_out      = rgb_q.g;
    assign b_out      = rgb_q.b;
    assign hs_out     = hs2_q;
    assign vs_out     = vs2_q;
    assign blank_out  = blank2_q;
    assign inv_active = inv;

endmodule

// File: doc/cs_video_mixer.md
# cs_video_mixer

Pixel-domain video mixer for the Computer Space core. Sits between `computer_space_top` and `mist_video`. It turns the four discrete video layer bits (score, saucer, ship, invert) plus sync/blank into aligned 4-bit RGB, using a saturating additive palette and a frame-synchronous screen-inversion (explosion flash) tracker. All work is a two-stage pipeline clocked by `clk_sys` and gated by a pixel clock enable.

## Interface
- `INV_HOLD_FRAMES`, default 1: number of whole frames the inversion stays active after a frame that requested it; legal range 1..15.
- `clk_sys` in 1: system clock; all state is sampled on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ce_pix` in 1: pixel clock enable; the pipeline and tracker advance only when it is 1.
- `color` in 1: 1 selects the colour palette, 0 selects the monochrome palette.
- `video_in` in 4: layer bits; [0] score, [1] saucer, [2] ship, [3] invert request.
- `hs_in`, `vs_in`, `blank_in` in 1 each: raw sync and blank from the game.
- `r_out`, `g_out`, `b_out` out 4 each: mixed pixel.
- `hs_out`, `vs_out`, `blank_out` out 1 each: sync and blank delayed to match the pixel.
- `inv_active` out 1: the inversion currently applied to output.

## Operation
- **Stage 1** (on `ce_pix`): register `video_in[2:0]`, `hs_in`, `vs_in` and `blank_in`. Compute per-channel 6-bit sums as score + saucer + ship.
  - Score always contributes (7,7,7).
  - Saucer contributes (0,15,15) if `color`, else (7,7,7).
  - Ship contributes (15,15,0) if `color`, else (15,15,15).
  - A layer whose bit is 0 contributes 0.
- **Saturation:** if a channel sum is above 15, the channel is 15; otherwise it is `sum[3:0]`.
- **Stage 2** (on `ce_pix`): channel = saturated value XOR {4{inv}}, then forced to 0 when the delayed blank is 1. Blank wins over inversion.
- **Inversion tracker:**
  - `req` is a sticky flag. It is set by any `ce_pix` cycle with `video_in[3]` = 1.
  - `cnt` is a 4-bit frame counter.
  - `inv` = (`cnt` != 0).
  - A vsync rising edge is `vs_in`=1 while the previous ce-sampled `vs_in` was 0.
  - On an edge: if `req` is set, `cnt` loads `INV_HOLD_FRAMES`; otherwise `cnt` decrements, saturating at 0. `req` then clears.
  - **Simultaneous event:** if `video_in[3]`=1 on the edge cycle, the request counts toward the new frame. `req` ends that cycle at 1, and the current `cnt` update uses the old `req`.
- **Reset values:** RGB 0, `hs_out`=0, `vs_out`=0, `blank_out`=1, `inv_active`=0, `req`=0, `cnt`=0, previous-vs=0.
- **Reset mid-frame:** all of the above are restored immediately. The first vsync edge after release may only decrement (no-op at 0).

## Timing
- Latency from `video_in`/sync/blank to outputs is exactly 2 `ce_pix` cycles. Sync and blank carry identical delay.
- With `ce_pix` held low, every register holds its value.
- `inv` changes only on the cycle after a ce-qualified vsync edge. This inversion change takes effect at stage 2 on the next `ce_pix`, during vertical blank.
- `inv_active` mirrors `inv` with no further delay.

## Configuration
- Macro: `CS_VIDEO_COLOR_EN`.
- **Defined:** `color` selects the palette as above.
- **Undefined:** `color` is ignored and the monochrome palette is hard-wired. The port remains present.

## Structure
- **Package `cs_video_pkg`** holds:
  - `localparam` channel width (4) and sum width (6);
  - palette constants `PAL_SCORE`, `PAL_SAUCER_MONO`, `PAL_SAUCER_COL`, `PAL_SHIP_MONO`, `PAL_SHIP_COL`;
  - `typedef struct packed rgb4_t {r,g,b}` and `rgb6_t` for the sums.
- **Sub-module `cs_inv_tracker`** contains vsync edge detect, `req` and `cnt`. Ports: `clk_sys`, `reset_n`, `ce_pix`, `vs_in`, `inv_req`, `inv`.

## Test plan
- **Mono mix:** `color`=0, `video_in`=4'b0011 → after 2 ce, RGB=(14,14,14). With `video_in`=4'b0111 → (15,15,15) saturated.
- **Colour mix:** `color`=1, ship only → (15,15,0). Saucer + score → (7,15,15). With `CS_VIDEO_COLOR_EN` undefined, the same saucer + score stimulus → (14,14,14).
- **Blank priority:** `blank_in`=1 with `inv`=1 and all layers on → RGB=0 and `blank_out`=1 exactly 2 ce later.
- **Inversion hold:** `INV_HOLD_FRAMES`=2, pulse `video_in[3]` once in frame N → `inv_active`=1 for frames N+1 and N+2, 0 from N+3. A background-only pixel outputs (15,15,15) while inverted.
- **Edge collision:** `video_in[3]`=1 only on the vsync-edge ce cycle, with no prior request → inversion starts one frame later, not immediately.
- **Reset mid-operation:** assert `reset_n`=0 with `cnt`=2 mid-line → outputs read 0/0/0, `blank_out`=1, `inv_active`=0 asynchronously. The pipeline refills 2 ce after release.
